// File: rtl/frog_mover_if.sv
// rtl/frog_mover_if.sv - button/collision pulses in, frog position and game status out
interface frog_mover_if #(
    parameter int ROW_W   = 4,
    parameter int COL_W   = 4,
    parameter int SCORE_W = 4
);
    logic               up;
    logic               down;
    logic               left;
    logic               right;
    logic               hit;
    logic               restart;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic               frog_visible;
    logic [SCORE_W-1:0] score;
    logic [2:0]         lives;
    logic               win_pulse;
    logic               game_over;

    modport master (
        output up, down, left, right, hit, restart,
        input  row, col, frog_visible, score, lives, win_pulse, game_over
    );

    modport slave (
        input  up, down, left, right, hit, restart,
        output row, col, frog_visible, score, lives, win_pulse, game_over
    );
endinterface

// File: rtl/frog_mover.sv
// rtl/frog_mover.sv - frog position tracking and round state machine (play, win, dead, over)
module frog_mover #(
    parameter int ROWS        = 16,
    parameter int COLS        = 16,
    parameter int START_COL   = 7,
    parameter int LIVES       = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int SCORE_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    frog_mover_if.slave bus
);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]   ROW_ONE    = ROW_W'(1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]   COL_ONE    = COL_W'(1);
    localparam logic [COL_W-1:0]   COL_START  = COL_W'(START_COL);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        DEAD = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               vis_q, vis_d;
    logic               win_q, win_d;
    logic               over_q, over_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PLAY;
            row_q   <= ROW_LAST;
            col_q   <= COL_START;
            score_q <= '0;
            lives_q <= LIVES_INIT;
            hold_q  <= '0;
            vis_q   <= 1'b1;
            win_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            score_q <= score_d;
            lives_q <= lives_d;
            hold_q  <= hold_d;
            vis_q   <= vis_d;
            win_q   <= win_d;
            over_q  <= over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        score_d = score_q;
        lives_d = lives_q;
        hold_d  = hold_q;
        vis_d   = vis_q;
        win_d   = 1'b0;
        case (state_q)
            PLAY: begin
                if (bus.hit) begin
                    if (lives_q == 3'd1) begin
                        lives_d = 3'd0;
                        state_d = OVER;
                    end else begin
                        lives_d = lives_q - 3'd1;
                        state_d = DEAD;
                        hold_d  = '0;
                        vis_d   = 1'b0;
                    end
                end else if (bus.up) begin
                    // Out-of-grid moves are swallowed; the lower-priority pulses stay dropped.
                    if (row_q != '0) begin
                        row_d = row_q - ROW_ONE;
                        if (row_q == ROW_ONE) begin
                            state_d = WIN;
                            hold_d  = '0;
                            win_d   = 1'b1;
                            if (score_q != SCORE_MAX)
                                score_d = score_q + SCORE_ONE;
                        end
                    end
                end else if (bus.down) begin
                    if (row_q != ROW_LAST)
                        row_d = row_q + ROW_ONE;
                end else if (bus.left) begin
                    if (col_q != '0)
                        col_d = col_q - COL_ONE;
                end else if (bus.right) begin
                    if (col_q != COL_LAST)
                        col_d = col_q + COL_ONE;
                end
            end
            WIN, DEAD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = PLAY;
                    row_d   = ROW_LAST;
                    col_d   = COL_START;
                    hold_d  = '0;
                    vis_d   = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                    if (state_q == DEAD)
                        vis_d = ~vis_q;
                end
            end
            OVER: begin
                vis_d = 1'b1;
                if (bus.restart) begin
                    state_d = PLAY;
                    row_d   = ROW_LAST;
                    col_d   = COL_START;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = PLAY;
                row_d   = ROW_LAST;
                col_d   = COL_START;
                score_d = '0;
                lives_d = LIVES_INIT;
                hold_d  = '0;
                vis_d   = 1'b1;
            end
        endcase
        over_d = (state_d == OVER);
    end

    assign bus.row          = row_q;
    assign bus.col          = col_q;
    assign bus.frog_visible = vis_q;
    assign bus.score        = score_q;
    assign bus.lives        = lives_q;
    assign bus.win_pulse    = win_q;
    assign bus.game_over    = over_q;
endmodule

// File: tb/tb_frog_mover.sv
// tb/tb_frog_mover.sv - self-checking bench for frog_mover against a behavioural game model
module tb_frog_mover;
    localparam int ROWS = 16, COLS = 16, START_COL = 7, LIVES = 3, HOLD = 8, SCORE_W = 4;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;
    localparam int M_PLAY = 0, M_WIN = 1, M_DEAD = 2, M_OVER = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   asserts_cnt = 0;
    int   fail_cnt = 0;

    frog_mover_if #(.ROW_W(4), .COL_W(4), .SCORE_W(SCORE_W)) ifc ();

    frog_mover #(
        .ROWS(ROWS), .COLS(COLS), .START_COL(START_COL),
        .LIVES(LIVES), .HOLD_CYCLES(HOLD), .SCORE_W(SCORE_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int m_row, m_col, m_score, m_lives, m_vis, m_win, m_mode, m_left;

    logic [17:0] dut_vec;
    assign dut_vec = {ifc.row, ifc.col, ifc.frog_visible, ifc.score, ifc.lives,
                      ifc.win_pulse, ifc.game_over};

    function automatic logic [17:0] model_vec();
        logic [17:0] v;
        v = {4'(m_row), 4'(m_col), 1'(m_vis), 4'(m_score), 3'(m_lives),
             1'(m_win), 1'(m_mode == M_OVER)};
        return v;
    endfunction

    task automatic model_reset();
        m_row = ROWS - 1; m_col = START_COL; m_score = 0; m_lives = LIVES;
        m_vis = 1; m_win = 0; m_mode = M_PLAY; m_left = 0;
    endtask

    task automatic model_step(input bit u, d, l, r, h, rs);
        m_win = 0;
        case (m_mode)
            M_PLAY: begin
                if (h) begin
                    if (m_lives == 1) begin
                        m_lives = 0; m_mode = M_OVER;
                    end else begin
                        m_lives--; m_mode = M_DEAD; m_left = HOLD; m_vis = 0;
                    end
                end else if (u) begin
                    if (m_row > 0) begin
                        m_row--;
                        if (m_row == 0) begin
                            m_mode = M_WIN; m_left = HOLD; m_win = 1;
                            if (m_score < SCORE_MAX) m_score++;
                        end
                    end
                end else if (d) begin
                    if (m_row < ROWS - 1) m_row++;
                end else if (l) begin
                    if (m_col > 0) m_col--;
                end else if (r) begin
                    if (m_col < COLS - 1) m_col++;
                end
            end
            M_WIN, M_DEAD: begin
                m_left--;
                if (m_left == 0) begin
                    m_row = ROWS - 1; m_col = START_COL; m_vis = 1; m_mode = M_PLAY;
                end else if (m_mode == M_DEAD) begin
                    m_vis = 1 - m_vis;
                end
            end
            default: if (rs) model_reset();
        endcase
    endtask

    task automatic cycle(input bit u, d, l, r, h, rs);
        ifc.up = u; ifc.down = d; ifc.left = l; ifc.right = r; ifc.hit = h; ifc.restart = rs;
        @(posedge clk);
        #1;
        model_step(u, d, l, r, h, rs);
        ifc.up = 0; ifc.down = 0; ifc.left = 0; ifc.right = 0; ifc.hit = 0; ifc.restart = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ifc.up = 0; ifc.down = 0; ifc.left = 0; ifc.right = 0; ifc.hit = 0; ifc.restart = 0;
        do_reset();
        asserts_cnt++;
        if (ifc.row !== 4'd15) begin fail_cnt++; $display("FAIL reset_row: got %0d expected 15", ifc.row); end
        asserts_cnt++;
        if (ifc.col !== 4'd7) begin fail_cnt++; $display("FAIL reset_col: got %0d expected 7", ifc.col); end
        asserts_cnt++;
        if (ifc.score !== 4'd0) begin fail_cnt++; $display("FAIL reset_score: got %0d expected 0", ifc.score); end
        asserts_cnt++;
        if (ifc.lives !== 3'd3) begin fail_cnt++; $display("FAIL reset_lives: got %0d expected 3", ifc.lives); end
        asserts_cnt++;
        if ({ifc.frog_visible, ifc.win_pulse, ifc.game_over} !== 3'b100) begin
            fail_cnt++;
            $display("FAIL reset_flags: got %b expected 100", {ifc.frog_visible, ifc.win_pulse, ifc.game_over});
        end
    endtask

    task automatic test_moves();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);
        asserts_cnt++;
        if (ifc.col !== 4'd10) begin fail_cnt++; $display("FAIL move_right: got %0d expected 10", ifc.col); end
        for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 0, 0);
        asserts_cnt++;
        if (dut_vec !== model_vec() || ifc.col !== 4'd8) begin
            fail_cnt++; $display("FAIL move_left: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 0, 0);
        asserts_cnt++;
        if (ifc.col !== 4'd0) begin fail_cnt++; $display("FAIL clamp_left: got %0d expected 0", ifc.col); end
        cycle(0, 1, 0, 0, 0, 0);
        asserts_cnt++;
        if (ifc.row !== 4'd15 || dut_vec !== model_vec()) begin
            fail_cnt++; $display("FAIL clamp_down: got row %0d expected 15", ifc.row);
        end
    endtask

    task automatic test_priority();
        cycle(1, 0, 1, 1, 0, 0);
        asserts_cnt++;
        if (ifc.row !== 4'd14 || ifc.col !== 4'd0) begin
            fail_cnt++; $display("FAIL priority_up: got row %0d col %0d expected row 14 col 0", ifc.row, ifc.col);
        end
    endtask

    task automatic test_win();
        int pulses;
        for (int i = 0; i < 13; i++) cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        asserts_cnt++;
        if (ifc.row !== 4'd0 || ifc.win_pulse !== 1'b1 || ifc.score !== 4'd1) begin
            fail_cnt++; $display("FAIL win_entry: got row %0d pulse %b score %0d expected 0 1 1",
                                 ifc.row, ifc.win_pulse, ifc.score);
        end
        pulses = 1;
        for (int i = 0; i < HOLD; i++) begin
            cycle(1, 0, 0, 0, 1, 0);
            if (ifc.win_pulse === 1'b1) pulses++;
            asserts_cnt++;
            if (dut_vec !== model_vec()) begin
                fail_cnt++; $display("FAIL win_hold_%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        asserts_cnt++;
        if (pulses != 1 || ifc.row !== 4'd15 || ifc.col !== 4'd7) begin
            fail_cnt++; $display("FAIL win_exit: got pulses %0d row %0d col %0d expected 1 15 7",
                                 pulses, ifc.row, ifc.col);
        end
    endtask

    task automatic test_hits();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        asserts_cnt++;
        if (ifc.lives !== 3'd2 || ifc.frog_visible !== 1'b0 || ifc.row !== 4'd12) begin
            fail_cnt++; $display("FAIL hit_entry: got lives %0d vis %b row %0d expected 2 0 12",
                                 ifc.lives, ifc.frog_visible, ifc.row);
        end
        for (int i = 1; i <= HOLD; i++) begin
            cycle(1, 0, 0, 0, 1, 1);
            asserts_cnt++;
            if (ifc.frog_visible !== ((i == HOLD) ? 1'b1 : 1'(i % 2)) || dut_vec !== model_vec()) begin
                fail_cnt++; $display("FAIL dead_blink_%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        cycle(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < HOLD; i++) cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        asserts_cnt++;
        if (ifc.lives !== 3'd0 || ifc.game_over !== 1'b1) begin
            fail_cnt++; $display("FAIL game_over: got lives %0d over %b expected 0 1", ifc.lives, ifc.game_over);
        end
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 0);
        asserts_cnt++;
        if (ifc.row !== 4'd15 || dut_vec !== model_vec()) begin
            fail_cnt++; $display("FAIL over_frozen: got %h expected %h", dut_vec, model_vec());
        end
        cycle(0, 0, 0, 0, 0, 1);
        asserts_cnt++;
        if (ifc.lives !== 3'd3 || ifc.score !== 4'd0 || ifc.game_over !== 1'b0) begin
            fail_cnt++; $display("FAIL restart: got lives %0d score %0d over %b expected 3 0 0",
                                 ifc.lives, ifc.score, ifc.game_over);
        end
    endtask

    task automatic test_goal_hit();
        int score_before;
        for (int i = 0; i < 14; i++) cycle(1, 0, 0, 0, 0, 0);
        score_before = m_score;
        cycle(1, 0, 0, 0, 1, 0);
        asserts_cnt++;
        if (ifc.row !== 4'd1 || ifc.win_pulse !== 1'b0 || ifc.lives !== 3'd2 ||
            ifc.score !== 4'(score_before) || dut_vec !== model_vec()) begin
            fail_cnt++; $display("FAIL hit_beats_goal: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        asserts_cnt++;
        if (dut_vec !== model_vec()) begin
            fail_cnt++; $display("FAIL async_reset: got %h expected %h", dut_vec, model_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);
        asserts_cnt++;
        if (dut_vec !== model_vec()) begin
            fail_cnt++; $display("FAIL after_reset: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        bit u, d, l, r, h, rs;
        for (int i = 0; i < 600; i++) begin
            u  = ($urandom_range(0, 99) < 35);
            d  = ($urandom_range(0, 99) < 12);
            l  = ($urandom_range(0, 99) < 20);
            r  = ($urandom_range(0, 99) < 20);
            h  = ($urandom_range(0, 99) < 5);
            rs = ($urandom_range(0, 99) < 15);
            cycle(u, d, l, r, h, rs);
            asserts_cnt++;
            if (dut_vec !== model_vec()) begin
                fail_cnt++; $display("FAIL random_%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_moves();
        test_clamp();
        test_priority();
        test_win();
        test_hits();
        test_goal_hit();
        test_async_reset();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts_cnt, fail_cnt);
        $finish;
    end
endmodule
